// File: rtl/spi_frame_master.sv
// spi_frame_master: host side of a framed SPI link; clocks FRAME_BYTES bytes out in SPI mode 0, MSB first.
// Latency: first SCK rise GAP_CYCLES+CLK_DIV+1 cycles after iSTART; oFRAME_n is low for exactly
//   GAP_CYCLES*(FRAME_BYTES+1) + (16*CLK_DIV+1)*FRAME_BYTES cycles, then oDONE pulses for one cycle.
// Backpressure: none; TX buffer answers one cycle after oTX_ADDR, RX port takes every oRX_WE; iSTART while busy is dropped.
//
// Ports:
//   iCLK, iRESETn             clock (rising edge) and async active-low reset
//   iSTART / oBUSY / oDONE    frame request, frame in progress, end-of-frame pulse
//   oTX_ADDR / iTX_DATA       TX byte buffer read port (1-cycle read latency)
//   oRX_WE/oRX_ADDR/oRX_DATA  RX byte write port
//   oFRAME_n, oSPI_SS_n       frame-active and slave select, both low for the whole frame
//   oSPI_SCK/MOSI/MISO        SPI wires, SCK idles low
module spi_frame_master #(
    parameter int FRAME_BYTES = 20,
    parameter int CLK_DIV     = 3,
    parameter int GAP_CYCLES  = 2
) (
    input  logic       iCLK,
    input  logic       iRESETn,
    input  logic       iSTART,
    output logic       oBUSY,
    output logic       oDONE,
    output logic [7:0] oTX_ADDR,
    input  logic [7:0] iTX_DATA,
    output logic       oRX_WE,
    output logic [7:0] oRX_ADDR,
    output logic [7:0] oRX_DATA,
    output logic       oFRAME_n,
    output logic       oSPI_SS_n,
    output logic       oSPI_SCK,
    output logic       oSPI_MOSI,
    input  logic       iSPI_MISO
);

    localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [7:0]       LAST_BYTE = 8'(FRAME_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SHIFT,
        GAP,
        TRAIL,
        FINISH
    } stateT;

    stateT            state, stateNext;
    logic [CNT_W-1:0] cnt, cntNext;
    logic [2:0]       bitCnt, bitCntNext;
    logic [7:0]       byteIdx, byteIdxNext;
    logic [7:0]       txShift, txShiftNext;
    logic [7:0]       rxShift, rxShiftNext;
    logic             sck, sckNext;
    logic             mosi, mosiNext;
    logic             byteEnd, byteEndNext;   // decision cycle after the 8th high phase
    logic [7:0]       txAddr, txAddrNext;
    logic             rxWe, rxWeNext;
    logic [7:0]       rxAddr, rxAddrNext;
    logic [7:0]       rxData, rxDataNext;
    logic             frameActive;

    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            state   <= IDLE;
            cnt     <= '0;
            bitCnt  <= '0;
            byteIdx <= '0;
            txShift <= '0;
            rxShift <= '0;
            sck     <= 1'b0;
            mosi    <= 1'b0;
            byteEnd <= 1'b0;
            txAddr  <= '0;
            rxWe    <= 1'b0;
            rxAddr  <= '0;
            rxData  <= '0;
        end else begin
            state   <= stateNext;
            cnt     <= cntNext;
            bitCnt  <= bitCntNext;
            byteIdx <= byteIdxNext;
            txShift <= txShiftNext;
            rxShift <= rxShiftNext;
            sck     <= sckNext;
            mosi    <= mosiNext;
            byteEnd <= byteEndNext;
            txAddr  <= txAddrNext;
            rxWe    <= rxWeNext;
            rxAddr  <= rxAddrNext;
            rxData  <= rxDataNext;
        end
    end

    always_comb begin
        stateNext   = state;
        cntNext     = cnt;
        bitCntNext  = bitCnt;
        byteIdxNext = byteIdx;
        txShiftNext = txShift;
        rxShiftNext = rxShift;
        sckNext     = sck;
        mosiNext    = mosi;
        byteEndNext = byteEnd;
        txAddrNext  = txAddr;
        rxWeNext    = 1'b0;
        rxAddrNext  = rxAddr;
        rxDataNext  = rxData;

        case (state)
            IDLE: begin
                if (iSTART) begin
                    stateNext   = LEAD;
                    cntNext     = '0;
                    byteIdxNext = '0;
                    txAddrNext  = '0;
                end
            end

            // The address was set on entry, so by the last cycle iTX_DATA holds the byte.
            LEAD, GAP: begin
                if (cnt == GAP_LAST) begin
                    stateNext   = SHIFT;
                    cntNext     = '0;
                    txShiftNext = iTX_DATA;
                    mosiNext    = iTX_DATA[7];
                    bitCntNext  = '0;
                    sckNext     = 1'b0;
                    byteEndNext = 1'b0;
                end else begin
                    cntNext = cnt + CNT_W'(1);
                end
            end

            SHIFT: begin
                if (byteEnd) begin
                    rxWeNext    = 1'b1;
                    rxAddrNext  = byteIdx;
                    rxDataNext  = rxShift;
                    byteEndNext = 1'b0;
                    cntNext     = '0;
                    if (byteIdx == LAST_BYTE) begin
                        stateNext = TRAIL;
                    end else begin
                        byteIdxNext = byteIdx + 8'd1;
                        txAddrNext  = byteIdx + 8'd1;
                        stateNext   = GAP;
                    end
                end else if (cnt != DIV_LAST) begin
                    cntNext = cnt + CNT_W'(1);
                end else begin
                    cntNext = '0;
                    if (!sck) begin
                        // Rising SCK: capture MISO on the same edge that raises the clock.
                        sckNext     = 1'b1;
                        rxShiftNext = {rxShift[6:0], iSPI_MISO};
                    end else begin
                        sckNext = 1'b0;
                        if (bitCnt == 3'd7) begin
                            byteEndNext = 1'b1;
                            mosiNext    = 1'b0;
                        end else begin
                            bitCntNext  = bitCnt + 3'd1;
                            mosiNext    = txShift[6];
                            txShiftNext = {txShift[6:0], 1'b0};
                        end
                    end
                end
            end

            TRAIL: begin
                if (cnt == GAP_LAST) begin
                    stateNext = FINISH;
                end else begin
                    cntNext = cnt + CNT_W'(1);
                end
            end

            FINISH: stateNext = IDLE;

            default: stateNext = IDLE;
        endcase
    end

    // Frame/select/busy decode straight from state so reset releases them in the same cycle.
    assign frameActive = (state != IDLE) && (state != FINISH);
    assign oBUSY       = frameActive;
    assign oDONE       = (state == FINISH);
    assign oFRAME_n    = !frameActive;
    assign oSPI_SS_n   = !frameActive;
    assign oSPI_SCK    = sck;
    assign oSPI_MOSI   = mosi;
    assign oTX_ADDR    = txAddr;
    assign oRX_WE      = rxWe;
    assign oRX_ADDR    = rxAddr;
    assign oRX_DATA    = rxData;

endmodule
